// File: rtl/ps2_kbd_fifo_mmio_pkg.sv
// Shared configuration for the PS/2 keyboard MMIO front end:
// register offsets, scan-code constants and the address decoder.
package ps2_kbd_fifo_mmio_pkg;

   localparam logic [31:0] BASE_ADDR_DEF = 32'hFF20_0000;

   localparam logic [31:0] OFF_CTRL    = 32'h00;
   localparam logic [31:0] OFF_DATA    = 32'h04;
   localparam logic [31:0] OFF_HIST0   = 32'h08;
   localparam logic [31:0] OFF_KEYMAP0 = 32'h20;

   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_CTRL,
      SEL_DATA,
      SEL_HIST,
      SEL_KMAP
   } reg_sel_e;

   typedef struct packed {
      reg_sel_e   sel;
      logic [1:0] idx;
   } reg_hit_t;

   function automatic reg_hit_t reg_decode(
      input logic [31:0] off,
      input int unsigned hist_words
   );
      reg_hit_t r;
      r.sel = SEL_NONE;
      r.idx = off[3:2];
      if (off[1:0] == 2'b00) begin
         if (off == OFF_CTRL) begin
            r.sel = SEL_CTRL;
         end else if (off == OFF_DATA) begin
            r.sel = SEL_DATA;
         end else if (off >= OFF_HIST0 &&
                      off < OFF_HIST0 + 4 * hist_words) begin
            r.sel = SEL_HIST;
            r.idx = 2'((off - OFF_HIST0) >> 2);
         end else if (off >= OFF_KEYMAP0 &&
                      off < OFF_KEYMAP0 + 32'h10) begin
            r.sel = SEL_KMAP;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ps2_kbd_fifo_mmio_if.sv
// IO-bus request side shared by the CPU and the keyboard slave.
interface ps2_kbd_fifo_mmio_if;

   logic        wReadEnable;
   logic        wWriteEnable;
   logic [3:0]  wByteEnable;
   logic [31:0] wAddress;
   logic [31:0] wWriteData;

   modport master (
      output wReadEnable, wWriteEnable, wByteEnable,
      output wAddress, wWriteData
   );

   modport slave (
      input wReadEnable, wWriteEnable, wByteEnable,
      input wAddress, wWriteData
   );

endinterface

// File: rtl/kbd_sync_fifo.sv
// Synchronous FIFO; a simultaneous push and pop always both take
// effect, a push into a full FIFO without a pop is dropped.
module kbd_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf_pulse
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full      = count == (AW+1)'(DEPTH);
   assign empty     = count == '0;
   assign do_push   = push & (~full | pop);
   assign do_pop    = pop & (~empty | push);
   assign ovf_pulse = push & full & ~pop;
   assign head      = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_kbd_fifo_mmio.sv
// PS/2 keyboard MMIO front end: prefix tracking, ASCII FIFO,
// scan history, key-state map and a maskable level interrupt.
module ps2_kbd_fifo_mmio
   import ps2_kbd_fifo_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF,
   parameter int          FIFO_DEPTH = 16,
   parameter int          HIST_WORDS = 2
) (
   input  logic               iCLK,
   input  logic               Reset,
   input  logic               scan_valid_i,
   input  logic [7:0]         scan_code_i,
   output logic               shift_o,
   input  logic [7:0]         ascii_i,
   ps2_kbd_fifo_mmio_if.slave bus,
   output logic [31:0]        wReadData,
   output logic               keyboard_interrupt
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]              off;
   reg_hit_t                 hit;
   logic [31:0]              rdata;
   logic [HIST_WORDS*32-1:0] hist;
   logic [127:0]             keymap;
   logic                     brk;
   logic                     ext;
   logic                     ie;
   logic                     ovf;
   logic                     prev_rd;
   logic                     rd_data_sel;
   logic                     pop;
   logic                     push;
   logic                     ctrl_wr;
   logic                     is_shift;
   logic [7:0]               head;
   logic                     full;
   logic                     empty;
   logic [CW-1:0]            count;
   logic                     ovf_pulse;
   logic                     unused_bits;

   assign off = bus.wAddress - BASE_ADDR;
   assign hit = reg_decode(off, HIST_WORDS);

   assign rd_data_sel = bus.wReadEnable & (hit.sel == SEL_DATA);
   assign pop         = rd_data_sel & ~prev_rd;
   assign ctrl_wr     = bus.wWriteEnable & bus.wByteEnable[0] &
                        (hit.sel == SEL_CTRL);

   assign is_shift = (scan_code_i == SC_LSHIFT) |
                     (scan_code_i == SC_RSHIFT);

   // Codes >= 0x80 cover both prefixes, so they never reach the FIFO.
   assign push = scan_valid_i & ~scan_code_i[7] & ~brk & ~ext &
                 ~is_shift & (ascii_i != 8'h00);

   assign unused_bits = ^{bus.wByteEnable[3:1], bus.wWriteData[31:3],
                          bus.wWriteData[0], full};

   kbd_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (iCLK),
      .rst       (Reset),
      .push      (push),
      .pop       (pop),
      .din       (ascii_i),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .ovf_pulse (ovf_pulse)
   );

   always_ff @(posedge iCLK or posedge Reset) begin
      if (Reset) begin
         hist               <= '0;
         keymap             <= '0;
         brk                <= 1'b0;
         ext                <= 1'b0;
         shift_o            <= 1'b0;
         ie                 <= 1'b0;
         ovf                <= 1'b0;
         prev_rd            <= 1'b0;
         keyboard_interrupt <= 1'b0;
      end else begin
         if (scan_valid_i) begin
            hist <= {hist[HIST_WORDS*32-9:0], scan_code_i};
            if (scan_code_i == SC_BRK) begin
               brk <= 1'b1;
            end else if (scan_code_i == SC_EXT) begin
               ext <= 1'b1;
            end else begin
               if (!scan_code_i[7]) begin
                  keymap[scan_code_i[6:0]] <= ~brk;
                  if (is_shift && !ext) shift_o <= ~brk;
               end
               brk <= 1'b0;
               ext <= 1'b0;
            end
         end
         prev_rd <= rd_data_sel;
         if (ctrl_wr) ie <= bus.wWriteData[1];
         // A fresh overflow wins over a clear in the same cycle.
         if (ctrl_wr && bus.wWriteData[2]) ovf <= 1'b0;
         if (ovf_pulse) ovf <= 1'b1;
         keyboard_interrupt <= ie & ~empty;
      end
   end

   always_comb begin
      rdata = '0;
      unique case (hit.sel)
         SEL_CTRL: rdata = {16'b0, 8'(count), 5'b0, ovf, ie, ~empty};
         SEL_DATA: rdata = {23'b0, ~empty, empty ? 8'h00 : head};
         SEL_HIST: begin
            for (int k = 0; k < HIST_WORDS; k++) begin
               if (hit.idx == 2'(k)) rdata = hist[k*32 +: 32];
            end
         end
         SEL_KMAP: rdata = keymap[{hit.idx, 5'b0} +: 32];
         default:  rdata = '0;
      endcase
   end

   assign wReadData = (bus.wReadEnable && hit.sel != SEL_NONE) ?
                      rdata : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_ps2_kbd_fifo_mmio.sv
// Scoreboard bench for ps2_kbd_fifo_mmio against a queue-based
// reference model of the keyboard front end.
module tb_ps2_kbd_fifo_mmio;

   localparam logic [31:0] BASE  = 32'hFF20_0000;
   localparam int          DEPTH = 16;
   localparam int          HW    = 2;

   localparam logic [31:0] A_CTRL  = BASE;
   localparam logic [31:0] A_DATA  = BASE + 32'h04;
   localparam logic [31:0] A_HIST0 = BASE + 32'h08;
   localparam logic [31:0] A_HIST1 = BASE + 32'h0C;
   localparam logic [31:0] A_KM0   = BASE + 32'h20;
   localparam logic [31:0] A_KM3   = BASE + 32'h2C;

   logic        iCLK = 1'b0;
   logic        Reset;
   logic        scan_valid;
   logic [7:0]  scan_code;
   logic        shift_o;
   logic [7:0]  ascii;
   logic [31:0] wReadData;
   logic        irq;

   ps2_kbd_fifo_mmio_if bus ();

   always #5 iCLK = ~iCLK;

   function automatic logic [7:0] ascii_fn(input logic [7:0] c,
                                           input logic s);
      if (c >= 8'h10 && c < 8'h60 && c != 8'h12 && c != 8'h59)
         return (s ? 8'h41 : 8'h61) + 8'((int'(c) + 260 - 28) % 26);
      return 8'h00;
   endfunction

   assign ascii = ascii_fn(scan_code, shift_o);

   ps2_kbd_fifo_mmio #(
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (DEPTH),
      .HIST_WORDS (HW)
   ) dut (
      .iCLK               (iCLK),
      .Reset              (Reset),
      .scan_valid_i       (scan_valid),
      .scan_code_i        (scan_code),
      .shift_o            (shift_o),
      .ascii_i            (ascii),
      .bus                (bus),
      .wReadData          (wReadData),
      .keyboard_interrupt (irq)
   );

   // Reference model state
   logic [7:0] m_q[$];
   logic [7:0] m_hist[$];
   bit         m_km[128];
   bit         m_ovf, m_ie, m_shift, m_brk, m_ext;

   int n_err = 0;
   int n_chk = 0;

   logic [31:0] exp_q[$];
   logic [31:0] addr_q[$];
   logic        chk = 1'b0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic void m_reset();
      m_q.delete();
      m_hist.delete();
      for (int i = 0; i < 4*HW; i++) m_hist.push_back(8'h00);
      foreach (m_km[i]) m_km[i] = 1'b0;
      m_ovf = 0; m_ie = 0; m_shift = 0; m_brk = 0; m_ext = 0;
   endfunction

   function automatic void m_push(input logic [7:0] b);
      if (m_q.size() == DEPTH) m_ovf = 1;
      else m_q.push_back(b);
   endfunction

   function automatic void m_pop();
      if (m_q.size() != 0) void'(m_q.pop_front());
   endfunction

   function automatic void m_scan(input logic [7:0] c, input bit pop_same);
      logic [7:0] a;
      bit want;
      a = ascii_fn(c, m_shift);
      want = 0;
      m_hist.push_front(c);
      void'(m_hist.pop_back());
      if (c == 8'hF0) m_brk = 1;
      else if (c == 8'hE0) m_ext = 1;
      else begin
         if (c < 8'h80) begin
            m_km[c[6:0]] = !m_brk;
            if ((c == 8'h12 || c == 8'h59) && !m_ext) m_shift = !m_brk;
         end
         want = !m_brk && !m_ext && c < 8'h80 &&
                c != 8'h12 && c != 8'h59 && a != 8'h00;
         m_brk = 0;
         m_ext = 0;
      end
      if (want && pop_same) begin
         if (m_q.size() != 0) begin
            void'(m_q.pop_front());
            m_q.push_back(a);
         end
      end else begin
         if (want) m_push(a);
         if (pop_same) m_pop();
      end
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] off;
      logic [31:0] r;
      int k;
      off = a - BASE;
      r = '0;
      if (off == 32'h0) begin
         r = {16'b0, 8'(m_q.size()), 5'b0, m_ovf, m_ie, m_q.size() != 0};
      end else if (off == 32'h4) begin
         if (m_q.size() != 0) r = {23'b0, 1'b1, m_q[0]};
      end else if (off == 32'h8 || off == 32'hC) begin
         k = int'(off - 32'h8) / 4;
         r = {m_hist[4*k+3], m_hist[4*k+2], m_hist[4*k+1], m_hist[4*k]};
      end else if (off >= 32'h20 && off <= 32'h2C) begin
         k = int'(off - 32'h20) / 4;
         for (int b = 0; b < 32; b++) r[b] = m_km[k*32 + b];
      end
      return r;
   endfunction

   always @(negedge iCLK) begin : monitor
      logic [31:0] e;
      logic [31:0] a;
      if (chk) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL scoreboard: got read %h want nothing queued",
                     wReadData);
         end else begin
            e = exp_q.pop_front();
            a = addr_q.pop_front();
            check($sformatf("rd@%h", a), wReadData, e);
         end
      end
   end

   task automatic bus_read(input logic [31:0] a, input int hold);
      @(posedge iCLK); #2;
      exp_q.push_back(m_read(a));
      addr_q.push_back(a);
      bus.wReadEnable = 1'b1;
      bus.wAddress = a;
      chk = 1'b1;
      @(posedge iCLK); #2;
      chk = 1'b0;
      if (a == A_DATA) m_pop();
      repeat (hold - 1) begin
         @(posedge iCLK); #2;
      end
      bus.wReadEnable = 1'b0;
   endtask

   task automatic scan(input logic [7:0] c);
      @(posedge iCLK); #2;
      m_scan(c, 0);
      scan_valid = 1'b1;
      scan_code = c;
      @(posedge iCLK); #2;
      scan_valid = 1'b0;
   endtask

   task automatic scan_read(input logic [7:0] c, input logic [31:0] a);
      @(posedge iCLK); #2;
      exp_q.push_back(m_read(a));
      addr_q.push_back(a);
      m_scan(c, a == A_DATA);
      scan_valid = 1'b1;
      scan_code = c;
      bus.wReadEnable = 1'b1;
      bus.wAddress = a;
      chk = 1'b1;
      @(posedge iCLK); #2;
      chk = 1'b0;
      scan_valid = 1'b0;
      bus.wReadEnable = 1'b0;
   endtask

   task automatic wr_ctrl(input logic [31:0] d, input logic [3:0] be);
      @(posedge iCLK); #2;
      if (be[0]) begin
         m_ie = d[1];
         if (d[2]) m_ovf = 0;
      end
      bus.wWriteEnable = 1'b1;
      bus.wByteEnable = be;
      bus.wAddress = A_CTRL;
      bus.wWriteData = d;
      @(posedge iCLK); #2;
      bus.wWriteEnable = 1'b0;
   endtask

   function automatic logic [7:0] rand_code();
      case ($urandom_range(0, 9))
         0: return 8'hF0;
         1: return 8'hE0;
         2: return 8'h12;
         3: return 8'h59;
         4: return 8'($urandom_range(0, 127));
         5: return 8'($urandom_range(128, 255));
         default: return 8'($urandom_range(8'h15, 8'h4D));
      endcase
   endfunction

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 7))
         0: return A_CTRL;
         1: return A_DATA;
         2: return A_HIST0;
         3: return A_HIST1;
         4: return A_KM0;
         5: return A_KM0 + 32'h4;
         6: return A_KM0 + 32'h8;
         default: return A_KM3;
      endcase
   endfunction

   initial begin
      Reset = 1'b1;
      scan_valid = 1'b0;
      scan_code = 8'h00;
      bus.wReadEnable = 1'b0;
      bus.wWriteEnable = 1'b0;
      bus.wByteEnable = 4'h0;
      bus.wAddress = 32'h0;
      bus.wWriteData = 32'h0;
      m_reset();
      repeat (2) @(posedge iCLK);
      #2 Reset = 1'b0;

      // Reset state
      bus_read(A_CTRL, 1);
      bus_read(A_DATA, 1);
      bus_read(A_HIST0, 1);
      bus_read(A_KM0, 1);
      check("shift_rst", 32'(shift_o), 32'h0);
      check("irq_rst", 32'(irq), 32'h0);

      // Single make, held read pops once
      scan(8'h1C);
      check("ctrl_one", m_read(A_CTRL), 32'h0000_0101);
      bus_read(A_CTRL, 1);
      bus_read(A_DATA, 3);
      bus_read(A_DATA, 1);
      bus_read(A_CTRL, 1);
      scan(8'h1C);
      scan(8'h1D);
      bus_read(A_DATA, 3);
      bus_read(A_CTRL, 1);
      bus_read(A_DATA, 1);

      // Shift, break handling and history
      scan(8'h12);
      #1 check("shift_on", 32'(shift_o), 32'h1);
      scan(8'h1C);
      bus_read(A_KM0, 1);
      scan(8'hF0);
      scan(8'h1C);
      bus_read(A_KM0, 1);
      scan(8'hF0);
      scan(8'h12);
      #1 check("shift_off", 32'(shift_o), 32'h0);
      bus_read(A_HIST0, 1);
      bus_read(A_HIST1, 1);
      bus_read(A_DATA, 1);
      bus_read(A_DATA, 1);

      // Overflow, clear, full push+pop, ordered drain
      for (int i = 0; i < DEPTH + 1; i++) scan(8'h15 + 8'(i));
      bus_read(A_CTRL, 1);
      wr_ctrl(32'h4, 4'hF);
      bus_read(A_CTRL, 1);
      scan_read(8'h2A, A_DATA);
      bus_read(A_CTRL, 1);
      for (int i = 0; i < DEPTH; i++) bus_read(A_DATA, 1);
      bus_read(A_CTRL, 1);

      // Interrupt timing
      wr_ctrl(32'h2, 4'h1);
      scan(8'h1C);
      @(negedge iCLK) check("irq_lag", 32'(irq), 32'h0);
      @(negedge iCLK) check("irq_rise", 32'(irq), 32'h1);
      bus_read(A_DATA, 1);
      @(negedge iCLK) check("irq_hold", 32'(irq), 32'h1);
      @(negedge iCLK) check("irq_fall", 32'(irq), 32'h0);
      wr_ctrl(32'h0, 4'h1);
      scan(8'h1D);
      repeat (4) @(negedge iCLK) check("irq_masked", 32'(irq), 32'h0);
      bus_read(A_DATA, 1);

      // Extended codes
      scan(8'hE0);
      scan(8'h12);
      #1 check("ext_shift", 32'(shift_o), 32'h0);
      bus_read(A_CTRL, 1);
      scan(8'hE0);
      scan(8'h75);
      bus_read(A_KM3, 1);
      bus_read(A_CTRL, 1);

      // Asynchronous reset mid-sequence
      wr_ctrl(32'h2, 4'h1);
      scan(8'h12);
      for (int i = 0; i < 5; i++) scan(8'h20 + 8'(i));
      scan(8'hF0);
      @(negedge iCLK) check("irq_pre_rst", 32'(irq), 32'h1);
      bus.wReadEnable = 1'b1;
      bus.wAddress = A_CTRL;
      #2 Reset = 1'b1;
      m_reset();
      #1;
      check("irq_async", 32'(irq), 32'h0);
      check("shift_async", 32'(shift_o), 32'h0);
      check("ctrl_async", wReadData, 32'h0);
      @(posedge iCLK); #2;
      Reset = 1'b0;
      bus.wReadEnable = 1'b0;
      bus_read(A_CTRL, 1);
      bus_read(A_DATA, 1);
      bus_read(A_HIST0, 1);
      bus_read(A_KM0, 1);
      scan(8'h1C);
      bus_read(A_DATA, 1);

      // Randomised traffic
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: scan(rand_code());
            5, 6:          bus_read(rand_addr(), 1);
            7:             wr_ctrl($urandom, 4'($urandom_range(0, 15)));
            8:             bus_read(A_DATA, $urandom_range(1, 3));
            default:       scan_read(rand_code(), rand_addr());
         endcase
         @(posedge iCLK);
         @(negedge iCLK);
         check("irq_rand", 32'(irq), 32'(m_ie && m_q.size() != 0));
         check("shift_rand", 32'(shift_o), 32'(m_shift));
      end

      repeat (2) @(posedge iCLK);
      if (exp_q.size() != 0) begin
         n_chk++;
         n_err++;
         $display("FAIL scoreboard_drain: got %0d left want 0",
                  exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
